// File: rtl/cska_pipe_addsub.sv
// cska_pipe_addsub: pipelined carry-skip adder/subtractor with valid/ready handshake.
// Latency: result presented STAGES-1 edges after the accepting edge (final stage is the output register).
// Backpressure: global stall, all stages hold while out_valid & !out_ready; in_ready = adv & !rst.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake (a, b, cin, sub)
//   out_valid/out_ready      result handshake (sum, cout, ovf, zero)
//   op_count                 number of delivered results, wraps modulo 2^CNT_W
//
// Each stage handles BPS carry-skip blocks. Operand bits not yet consumed are
// carried forward with the item, and lower sum bits already produced travel
// alongside, so the final stage holds the complete result.
module cska_pipe_addsub #(
  parameter int N          = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int STAGES     = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  localparam int NBLK = N / BLOCK_SIZE;
  localparam int BPS  = (STAGES > 0) ? (NBLK / STAGES) : 1;
  localparam int W    = BPS * BLOCK_SIZE;

  if ((N % BLOCK_SIZE) != 0 || STAGES < 1 || STAGES > NBLK || (NBLK % STAGES) != 0) begin : g_bad_params
    $error("cska_pipe_addsub: illegal N/BLOCK_SIZE/STAGES combination");
  end

  logic         adv;
  logic [N-1:0] b_eff;
  logic         c0;

  // Subtraction is a + ~b + 1; cin acts as a borrow-in, hence the XOR.
  assign b_eff    = sub ? ~b : b;
  assign c0       = cin ^ sub;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv & !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * W;   // lowest bit handled by this stage
    localparam int HI = LO + W;  // first bit above this stage

    logic [N-1:LO] a_in;
    logic [N-1:LO] b_in;
    logic          c_in;
    logic          v_in;
    logic [W-1:0]  s_blk;
    logic          c_out;
    logic [HI-1:0] s_full;

    logic          v_r;
    logic          c_r;
    logic [HI-1:0] s_r;

    if (k == 0) begin : g_src
      assign a_in   = a;
      assign b_in   = b_eff;
      assign c_in   = c0;
      assign v_in   = in_valid & in_ready;
      assign s_full = s_blk;
    end else begin : g_src
      assign a_in   = g_stg[k-1].g_up.a_r;
      assign b_in   = g_stg[k-1].g_up.b_r;
      assign c_in   = g_stg[k-1].c_r;
      assign v_in   = g_stg[k-1].v_r;
      assign s_full = {s_blk, g_stg[k-1].s_r};
    end

    // Ripple inside each block; the block carry-out bypasses the ripple
    // chain when every bit of the block propagates.
    always_comb begin
      logic                  c;
      logic                  cb;
      logic [BLOCK_SIZE-1:0] p;
      s_blk = '0;
      c     = c_in;
      cb    = 1'b0;
      p     = '0;
      for (int j = 0; j < BPS; j++) begin
        cb = c;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
          p[i]                     = a_in[LO + j*BLOCK_SIZE + i] ^ b_in[LO + j*BLOCK_SIZE + i];
          s_blk[j*BLOCK_SIZE + i]  = p[i] ^ cb;
          cb = (a_in[LO + j*BLOCK_SIZE + i] & b_in[LO + j*BLOCK_SIZE + i]) | (p[i] & cb);
        end
        c = (&p) ? c : cb;
      end
      c_out = c;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (adv) begin
        v_r <= v_in;
        c_r <= c_out;
        s_r <= s_full;
      end
    end

    if (k < STAGES - 1) begin : g_up
      logic [N-1:HI] a_r;
      logic [N-1:HI] b_r;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (adv) begin
          a_r <= a_in[N-1:HI];
          b_r <= b_in[N-1:HI];
        end
      end
    end else begin : g_fin
      logic ovf_r;
      logic zero_r;
      // Carry into the MSB is recovered as a^b^sum at that bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (adv) begin
          ovf_r  <= a_in[N-1] ^ b_in[N-1] ^ s_blk[W-1] ^ c_out;
          zero_r <= (s_full == '0);
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_r;
  assign sum       = g_stg[STAGES-1].s_r;
  assign cout      = g_stg[STAGES-1].c_r;
  assign ovf       = g_stg[STAGES-1].g_fin.ovf_r;
  assign zero      = g_stg[STAGES-1].g_fin.zero_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cska_pipe_addsub.sv
// Directed bench for cska_pipe_addsub (N=32, BLOCK_SIZE=4, STAGES=4):
// edge vectors with latency checks, reset mid-flight, full-pipe stall and
// drain, then a randomized handshake run scored against an arithmetic model.
module tb_cska_pipe_addsub;
  localparam int STG = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b, sum, op_count;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic        cout, ovf, zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cska_pipe_addsub #(.N(32), .BLOCK_SIZE(4), .STAGES(STG), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
    .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain (N+1)-bit arithmetic, signed overflow from operand/result signs.
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic ms);
    logic [31:0] be;
    logic [32:0] r;
    logic        o;
    be = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + {32'd0, mc ^ ms};
    o  = (ma[31] == be[31]) && (r[31] != ma[31]);
    return {r[31:0], r[32], o, (r[31:0] == 32'd0)};
  endfunction

  // Called just after a posedge with an empty pipe and out_ready=1.
  // Checks in_ready, STG-1 bubble cycles, then the registered result.
  task automatic run(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                     input logic tc, input logic ts, input logic [31:0] es,
                     input logic ec, input logic eo, input logic ez);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk); chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < STG - 1; i++) begin
      @(negedge clk); chk({tag, "_latency_wait"}, out_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    chk({tag, "_zero"}, zero, ez);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] q[$];
    logic [34:0] exp_r;
    int          xfers;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf, zero}, 3'b000);
    chk("rst_op_count", op_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors: skip chain, overflow, subtraction, borrow-in
    run("carry_all",   32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1);
    run("pos_ovf",     32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0);
    run("sub_neg",     32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0, 0);
    run("sub_min_ovf", 32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0);
    run("add_cin",     32'h12345678, 32'h87654321, 1, 0, 32'h9999999A, 0, 0, 0);
    run("sub_borrow",  32'h0000000A, 32'h00000003, 1, 1, 32'h00000006, 1, 0, 0);
    run("sub_equal",   32'hAAAAAAAA, 32'hAAAAAAAA, 0, 1, 32'h00000000, 1, 0, 1);
    run("zero_cin",    32'h00000000, 32'h00000000, 1, 0, 32'h00000001, 0, 0, 0);
    run("neg_ovf",     32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1);
    @(negedge clk); chk("cnt_after_vectors", op_count, 9);
    @(posedge clk); #1;

    // Reset with three items in flight: nothing may emerge
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'h100 + i; b = 32'h1; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); chk("midrst_no_output", out_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk); chk("midrst_op_count", op_count, 0);
    @(posedge clk); #1;
    run("after_rst", 32'h00001234, 32'h00000FFF, 0, 0, 32'h00002233, 0, 0, 0);

    // Stall: 6 back-to-back offers with out_ready=0, exactly STG accepted
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = 32'h10 * i + 1; b = 32'h2; cin = 1'b0; sub = 1'b0;
      @(negedge clk); chk("fill_in_ready", in_ready, (i < STG) ? 1 : 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_sum_held", sum, 32'h3);
      chk("stall_op_count", op_count, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < STG; i++) begin
      @(negedge clk);
      chk("drain_out_valid", out_valid, 1);
      chk("drain_sum_order", sum, 32'h10 * i + 3);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_done", out_valid, 0);
    chk("drain_op_count", op_count, 5);
    @(posedge clk); #1;
    run("late_item4", 32'h00000041, 32'h2, 0, 0, 32'h00000043, 0, 0, 0);
    run("late_item5", 32'h00000051, 32'h2, 0, 0, 32'h00000053, 0, 0, 0);
    @(negedge clk); chk("stall_test_op_count", op_count, 7);
    @(posedge clk); #1;

    // Randomized handshake, scored against the model
    xfers = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = ~a; end
        1:       begin a = $urandom; b = a; end
        2:       begin a = {$urandom_range(0, 1) ? 1'b1 : 1'b0, {31{1'b1}}}; b = $urandom_range(0, 2); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      cin = $urandom_range(0, 1);
      sub = $urandom_range(0, 1);
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("rnd_expected_item", (q.size() != 0) ? 1 : 0, 1);
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          chk("rnd_result", {sum, cout, ovf, zero}, exp_r);
          xfers++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        exp_r = q.pop_front();
        chk("rnd_drain_result", {sum, cout, ovf, zero}, exp_r);
        xfers++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rnd_queue_empty", q.size(), 0);
    chk("rnd_pipe_empty", out_valid, 0);
    chk("rnd_op_count", op_count, 7 + xfers);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
